// File: rtl/kmkz_prefetch_buffer.sv
// rtl/kmkz_prefetch_buffer.sv - halfword instruction prefetch buffer with in-flight fetch tracking
module kmkz_prefetch_buffer #(
    parameter int DEPTH_HW        = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(DEPTH_HW) + 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_reset_i,
    input  logic        branch_i,
    input  logic [31:0] pc_set_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_comp_o
);

    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int OUT_W = 3;

    // Halfword storage; contents need no reset because count gates every read.
    logic [15:0]      hw_q [DEPTH_HW];
    logic [PTR_W-1:0] rp_q;
    logic [PTR_W-1:0] wp_q;
    logic [CNT_W-1:0] count_q;
    logic [OUT_W-1:0] outstanding_q;
    logic [OUT_W-1:0] discard_q;
    logic [31:0]      fetch_addr_q;
    logic [31:0]      head_pc_q;
    logic             skip_hw_q;

    logic [PTR_W-1:0] rp_p1;
    logic [PTR_W-1:0] wp_p1;
    logic [15:0]      hw_lo;
    logic [15:0]      hw_hi;
    logic             comp;
    logic [31:0]      free_hw;
    logic [31:0]      need_hw;
    logic             issue;
    logic             resp_keep;
    logic             pop;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] pop_n;
    logic [OUT_W-1:0] outstanding_nxt;

    // Head decode, fetch-issue window and per-cycle push/pop amounts.
    always_comb begin
        rp_p1   = rp_q + PTR_W'(1);
        wp_p1   = wp_q + PTR_W'(1);
        hw_lo   = hw_q[rp_q];
        hw_hi   = hw_q[rp_p1];
        comp    = (hw_lo[1:0] != 2'b11);

        // Reserve room for every in-flight word plus the new one, using the
        // registered count so a same-cycle pop never makes the check optimistic.
        free_hw = 32'(DEPTH_HW) - 32'(count_q);
        need_hw = (32'(outstanding_q) + 32'd1) << 1;

        mem_req_o  = !rst_i && !branch_i
                     && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                     && (free_hw >= need_hw);
        mem_addr_o = fetch_addr_q;

        instr_valid_o = !rst_i
                        && ((count_q >= CNT_W'(2)) || ((count_q == CNT_W'(1)) && comp));
        instr_comp_o  = comp;
        instr_o       = comp ? {16'h0000, hw_lo} : {hw_hi, hw_lo};
        instr_pc_o    = head_pc_q;

        issue     = mem_req_o && mem_gnt_i;
        resp_keep = mem_rvalid_i && (discard_q == '0);
        pop       = instr_valid_o && instr_ready_i;

        push_n = '0;
        if (resp_keep) begin
            push_n = skip_hw_q ? CNT_W'(1) : CNT_W'(2);
        end
        pop_n = '0;
        if (pop) begin
            pop_n = comp ? CNT_W'(1) : CNT_W'(2);
        end

        outstanding_nxt = outstanding_q;
        if (issue && !mem_rvalid_i) begin
            outstanding_nxt = outstanding_q + OUT_W'(1);
        end else if (!issue && mem_rvalid_i) begin
            outstanding_nxt = outstanding_q - OUT_W'(1);
        end
    end

    // Store response halfwords; a leading odd halfword after a redirect is skipped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !branch_i && resp_keep) begin
            if (skip_hw_q) begin
                hw_q[wp_q] <= mem_rdata_i[31:16];
            end else begin
                hw_q[wp_q]  <= mem_rdata_i[15:0];
                hw_q[wp_p1] <= mem_rdata_i[31:16];
            end
        end
    end

    // Pointer, occupancy, fetch and flush bookkeeping; a branch overrides push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rp_q          <= '0;
            wp_q          <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fetch_addr_q  <= {pc_reset_i[31:2], 2'b00};
            skip_hw_q     <= pc_reset_i[1];
            head_pc_q     <= pc_reset_i;
        end else begin
            outstanding_q <= outstanding_nxt;
            if (branch_i) begin
                rp_q         <= '0;
                wp_q         <= '0;
                count_q      <= '0;
                discard_q    <= outstanding_nxt;
                fetch_addr_q <= {pc_set_i[31:2], 2'b00};
                skip_hw_q    <= pc_set_i[1];
                head_pc_q    <= pc_set_i;
            end else begin
                if (issue) begin
                    fetch_addr_q <= fetch_addr_q + 32'd4;
                end
                if (mem_rvalid_i && (discard_q != '0)) begin
                    discard_q <= discard_q - OUT_W'(1);
                end
                if (resp_keep) begin
                    wp_q      <= skip_hw_q ? wp_p1 : (wp_q + PTR_W'(2));
                    skip_hw_q <= 1'b0;
                end
                if (pop) begin
                    rp_q      <= comp ? rp_p1 : (rp_q + PTR_W'(2));
                    head_pc_q <= head_pc_q + (comp ? 32'd2 : 32'd4);
                end
                count_q <= count_q + push_n - pop_n;
            end
        end
    end

endmodule

// File: tb/tb_kmkz_prefetch_buffer.sv
// tb/tb_kmkz_prefetch_buffer.sv - directed bench for kmkz_prefetch_buffer
module tb_kmkz_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_reset;
    logic        branch;
    logic [31:0] pc_set;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_comp;

    kmkz_prefetch_buffer #(.DEPTH_HW(8), .MAX_OUTSTANDING(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_reset_i    (pc_reset),
        .branch_i      (branch),
        .pc_set_i      (pc_set),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_comp_o  (instr_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] mem_words [logic [31:0]];
    logic [31:0] addr_log[$];
    int          req_cyc[$];
    logic [31:0] pop_instr[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_comp[$];
    int          pop_cyc[$];
    int          cyc;
    int          lat;
    int          total;
    int          bad;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        req_t r;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        mem_gnt = 1'b1;
        #1;
        if (mem_req && mem_gnt) begin
            r.addr = mem_addr;
            r.due  = cyc + lat;
            pend.push_back(r);
            addr_log.push_back(mem_addr);
            req_cyc.push_back(cyc);
        end
        if (instr_valid && instr_ready) begin
            pop_instr.push_back(instr);
            pop_pc.push_back(instr_pc);
            pop_comp.push_back({31'h0, instr_comp});
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input logic [31:0] pc);
        rst         = 1'b1;
        pc_reset    = pc;
        branch      = 1'b0;
        instr_ready = 1'b0;
        cycle();
        cycle();
        pend.delete();
        addr_log.delete();
        req_cyc.delete();
        pop_instr.delete();
        pop_pc.delete();
        pop_comp.delete();
        pop_cyc.delete();
        mem_rvalid = 1'b0;
        rst        = 1'b0;
        cyc        = 0;
        #1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        lat         = 1;
        rst         = 1'b1;
        pc_reset    = 32'h100;
        branch      = 1'b0;
        pc_set      = 32'h0;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        instr_ready = 1'b0;

        // Test 1: reset state, in-order 32-bit fetch, latency
        @(posedge clk);
        #1;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        mem_words.delete();
        mem_words[32'h100] = 32'h0000_0013;
        mem_words[32'h104] = 32'h0000_0093;
        do_reset(32'h100);
        check("t1_pc0", instr_pc, 32'h100);
        check("t1_valid0", {31'h0, instr_valid}, 32'h0);
        check("t1_req0", {31'h0, mem_req}, 32'h1);
        check("t1_addr0", mem_addr, 32'h100);
        instr_ready = 1'b1;
        run(10);
        check("t1_addr1", addr_log[1], 32'h104);
        check("t1_i0", pop_instr[0], 32'h0000_0013);
        check("t1_pc_0", pop_pc[0], 32'h100);
        check("t1_i1", pop_instr[1], 32'h0000_0093);
        check("t1_pc_1", pop_pc[1], 32'h104);
        check("t1_c1", pop_comp[1], 32'h0);
        check("t1_lat", 32'(pop_cyc[0] - req_cyc[0]), 32'd2);

        // Test 2: two RVC then a 32-bit instruction
        mem_words.delete();
        mem_words[32'h100] = 32'h4501_4501;
        mem_words[32'h104] = 32'h0000_0013;
        do_reset(32'h100);
        instr_ready = 1'b1;
        run(10);
        check("t2_i0", pop_instr[0], 32'h0000_4501);
        check("t2_pc0", pop_pc[0], 32'h100);
        check("t2_c0", pop_comp[0], 32'h1);
        check("t2_i1", pop_instr[1], 32'h0000_4501);
        check("t2_pc1", pop_pc[1], 32'h102);
        check("t2_i2", pop_instr[2], 32'h0000_0013);
        check("t2_pc2", pop_pc[2], 32'h104);
        check("t2_c2", pop_comp[2], 32'h0);

        // Test 3: branch to a misaligned target
        mem_words.delete();
        mem_words[32'h200] = 32'h4501_FFFF;
        mem_words[32'h204] = 32'h0000_0013;
        do_reset(32'h100);
        instr_ready = 1'b1;
        branch      = 1'b1;
        pc_set      = 32'h202;
        #1;
        check("t3_br_req", {31'h0, mem_req}, 32'h0);
        cycle();
        branch = 1'b0;
        run(8);
        check("t3_addr0", addr_log[0], 32'h200);
        check("t3_i0", pop_instr[0], 32'h0000_4501);
        check("t3_pc0", pop_pc[0], 32'h202);
        check("t3_c0", pop_comp[0], 32'h1);
        check("t3_i1", pop_instr[1], 32'h0000_0013);
        check("t3_pc1", pop_pc[1], 32'h204);

        // Test 4: fill to full, then drain across the wrap
        mem_words.delete();
        mem_words[32'h100] = 32'h0013_4501;
        mem_words[32'h104] = 32'h0093_AAAA;
        mem_words[32'h108] = 32'h0113_BBBB;
        mem_words[32'h10C] = 32'h0193_CCCC;
        mem_words[32'h110] = 32'h4501_DDDD;
        do_reset(32'h100);
        run(12);
        check("t4_nreq", 32'(addr_log.size()), 32'd4);
        check("t4_req_full", {31'h0, mem_req}, 32'h0);
        check("t4_valid_full", {31'h0, instr_valid}, 32'h1);
        check("t4_hold_i", instr, 32'h0000_4501);
        check("t4_hold_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        run(30);
        check("t4_i0", pop_instr[0], 32'h0000_4501);
        check("t4_i1", pop_instr[1], 32'hAAAA_0013);
        check("t4_pc1", pop_pc[1], 32'h102);
        check("t4_i2", pop_instr[2], 32'hBBBB_0093);
        check("t4_i3", pop_instr[3], 32'hCCCC_0113);
        check("t4_pc3", pop_pc[3], 32'h10A);
        check("t4_wrap_i", pop_instr[4], 32'hDDDD_0193);
        check("t4_wrap_pc", pop_pc[4], 32'h10E);
        check("t4_i5", pop_instr[5], 32'h0000_4501);
        check("t4_pc5", pop_pc[5], 32'h112);
        check("t4_i6", pop_instr[6], 32'h0000_0013);
        check("t4_pc6", pop_pc[6], 32'h114);

        // Test 5a: branch with two responses in flight, latency 3
        mem_words.delete();
        mem_words[32'h100] = 32'h0000_4501;
        mem_words[32'h104] = 32'h0000_4501;
        mem_words[32'h300] = 32'h00A0_0513;
        lat = 3;
        do_reset(32'h100);
        instr_ready = 1'b1;
        run(2);
        branch = 1'b1;
        pc_set = 32'h300;
        cycle();
        branch = 1'b0;
        run(15);
        check("t5a_nreq_pre", addr_log[2], 32'h300);
        check("t5a_i0", pop_instr[0], 32'h00A0_0513);
        check("t5a_pc0", pop_pc[0], 32'h300);
        check("t5a_cyc0", 32'(pop_cyc[0]), 32'd8);

        // Test 5b: response lands in the branch cycle, one left to discard
        mem_words.delete();
        mem_words[32'h100] = 32'h0000_4501;
        mem_words[32'h104] = 32'h0000_4501;
        mem_words[32'h400] = 32'h00B0_0593;
        lat = 2;
        do_reset(32'h100);
        instr_ready = 1'b1;
        run(2);
        branch = 1'b1;
        pc_set = 32'h400;
        cycle();
        branch = 1'b0;
        run(12);
        check("t5b_i0", pop_instr[0], 32'h00B0_0593);
        check("t5b_pc0", pop_pc[0], 32'h400);
        check("t5b_cyc0", 32'(pop_cyc[0]), 32'd6);

        // Test 6: branch in a cycle with both pop and push
        mem_words.delete();
        mem_words[32'h500] = 32'h00C0_0613;
        lat = 1;
        do_reset(32'h100);
        instr_ready = 1'b1;
        run(3);
        branch = 1'b1;
        pc_set = 32'h500;
        cycle();
        branch = 1'b0;
        #1;
        check("t6_valid", {31'h0, instr_valid}, 32'h0);
        check("t6_pc", instr_pc, 32'h500);
        check("t6_req", {31'h0, mem_req}, 32'h1);
        check("t6_addr", mem_addr, 32'h500);
        run(6);
        check("t6_pre_pc", pop_pc[1], 32'h104);
        check("t6_i2", pop_instr[2], 32'h00C0_0613);
        check("t6_pc2", pop_pc[2], 32'h500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
